// File: rtl/hc_sr04_pkg.sv
// rtl/hc_sr04_pkg.sv - HC-SR04 datasheet constants shared by the emulator and the distance receiver
package hc_sr04_pkg;

  localparam longint SOUND_SPEED_MPS = 343;
  localparam longint MAX_RANGE_CM    = 400;
  localparam longint MIN_RANGE_CM    = 2;
  localparam longint TRIG_US         = 10;
  localparam longint BURST_US        = 200;
  localparam longint TIMEOUT_MS      = 38;
  localparam longint MEAS_CYCLE_MS   = 60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_BURST,
    ST_ECHO,
    ST_WAIT_LOW
  } hc_state_t;

endpackage

// File: rtl/hc_sr04_emulator.sv
// rtl/hc_sr04_emulator.sv - HC-SR04 sensor emulator: trig pulse in, distance-coded echo pulse out
// Optional HC_SR04_EMULATOR_TIMEOUT_EN: out-of-range distance gives a no-target timeout echo instead of saturating.
module hc_sr04_emulator
  import hc_sr04_pkg::*;
#(
  parameter int clk_frequency  = 50000000,
  parameter int distance_width = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trig,
  input  logic [distance_width-1:0] distance,
  output logic                      echo,
  output logic                      busy
);

  localparam longint FREQ         = longint'(clk_frequency);
  localparam int     TRIG_TIME    = int'(TRIG_US * FREQ / 1000000);
  localparam int     BURST_TIME   = int'(BURST_US * FREQ / 1000000);
  localparam int     CPC          = int'(FREQ * 2 / SOUND_SPEED_MPS / 100);
  localparam int     TIMEOUT_TIME = int'(TIMEOUT_MS * FREQ / 1000);
  localparam int     DOWN_MAX     = (BURST_TIME > TIMEOUT_TIME) ? BURST_TIME : TIMEOUT_TIME;
  localparam int     TW           = $clog2(TRIG_TIME + 1);
  localparam int     CW           = $clog2(DOWN_MAX + 1);
  localparam int     IW           = $clog2(CPC + 1);
  localparam int     DW           = $clog2(MAX_RANGE_CM + 1);

  hc_state_t       state, state_d;
  logic            prev_trig;
  logic            fall;
  logic [TW-1:0]   trig_cnt;
  logic [CW-1:0]   down_cnt;
  logic [IW-1:0]   inner_cnt;
  logic [DW-1:0]   dist_q;
  logic [DW-1:0]   dist_eff;
  logic [31:0]     dist_ext;
  logic            over_range;
  logic            no_target;
  logic            echo_done;
  logic            echo_d, busy_d;

  assign fall       = prev_trig & ~trig;
  assign dist_ext   = 32'(distance);
  assign over_range = dist_ext > 32'(MAX_RANGE_CM);

  always_comb begin
    dist_eff = DW'(dist_ext);
    if (dist_ext < 32'(MIN_RANGE_CM))
      dist_eff = DW'(MIN_RANGE_CM);
    else if (over_range)
      dist_eff = DW'(MAX_RANGE_CM);
  end

  // A no-target echo times out on the shared down-counter; otherwise the nested counters measure distance.
  assign echo_done = no_target ? (down_cnt == '0)
                               : (inner_cnt == IW'(CPC - 1) && dist_q == DW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:     if (trig) state_d = ST_ARM;
      ST_ARM:      if (fall) state_d = (trig_cnt >= TW'(TRIG_TIME)) ? ST_BURST : ST_IDLE;
      ST_BURST:    if (down_cnt == '0) state_d = ST_ECHO;
      ST_ECHO:     if (echo_done) state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!trig) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    echo_d = (state_d == ST_ECHO);
    busy_d = (state_d == ST_BURST) || (state_d == ST_ECHO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo <= 1'b0;
      busy <= 1'b0;
    end else begin
      echo <= echo_d;
      busy <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_trig <= 1'b0;
      trig_cnt  <= '0;
      down_cnt  <= '0;
      inner_cnt <= '0;
      dist_q    <= '0;
    end else begin
      prev_trig <= trig;
      case (state)
        ST_IDLE: trig_cnt <= trig ? TW'(1) : '0;
        ST_ARM: begin
          if (trig && trig_cnt != TW'(TRIG_TIME))
            trig_cnt <= trig_cnt + TW'(1);
          if (state_d == ST_BURST) begin
            dist_q   <= dist_eff;
            down_cnt <= CW'(BURST_TIME - 1);
          end
        end
        ST_BURST: begin
          if (state_d == ST_ECHO) begin
            inner_cnt <= '0;
            down_cnt  <= CW'(TIMEOUT_TIME - 1);
          end else if (down_cnt != '0) begin
            down_cnt <= down_cnt - CW'(1);
          end
        end
        ST_ECHO: begin
          if (down_cnt != '0)
            down_cnt <= down_cnt - CW'(1);
          if (inner_cnt == IW'(CPC - 1)) begin
            inner_cnt <= '0;
            dist_q    <= dist_q - DW'(1);
          end else begin
            inner_cnt <= inner_cnt + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HC_SR04_EMULATOR_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      no_target <= 1'b0;
    else if (state == ST_ARM && state_d == ST_BURST)
      no_target <= over_range;
  end
`else
  assign no_target = 1'b0;
`endif

endmodule
